ram_scan_reader: RTL and testbench

Downstream consumer of the 32x4 RAM read port in the lab2 memory designs. It drives the RAM read address, advancing it automatically once per prescaled tick (one second at 50 MHz by default). It captures each returned word together with the address that produced it and presents the pair to the hexadecimal display stage. The block makes the RAM contents visible as a slow address scan with no user clocking.

---
 rtl/lab2_pkg.sv | 13 +
 rtl/ram_scan_reader_tick_gen.sv | 53 +++++
 rtl/ram_scan_reader.sv | 109 ++++++++++
 tb/tb_ram_scan_reader.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/lab2_pkg.sv
// Shared constants for the lab2 memory designs: RAM geometry and board clock.
package lab2_pkg;

  localparam int unsigned RAM_ADDR_W = 5;
  localparam int unsigned RAM_DATA_W = 4;
  localparam int unsigned CLK_HZ     = 50_000_000;

  // Width of a 0..div-1 counter, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/ram_scan_reader_tick_gen.sv
// Prescaler: counts enabled cycles and fires once every DIV of them.
// step is the combinational view of the firing edge; tick is its registered pulse.
module tick_gen
  import lab2_pkg::*;
#(
  parameter int unsigned DIV = CLK_HZ
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic step,
  output logic tick
);

  localparam int unsigned     CNT_W = cnt_width(DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // clear wins over a coinciding terminal count, so no step is reported then.
  assign step = enable && !clear && (cnt_q == LAST);
  assign tick = tick_q;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      if (cnt_q == LAST) begin
        cnt_d  = '0;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

endmodule

// File: rtl/ram_scan_reader.sv
// Slow address scanner for a synchronous RAM read port: steps rd_addr once per
// prescaled tick and shows each returned word alongside the address that fetched it.
module ram_scan_reader
  import lab2_pkg::*;
#(
  parameter int unsigned ADDR_W   = RAM_ADDR_W,
  parameter int unsigned DATA_W   = RAM_DATA_W,
  parameter int unsigned TICK_DIV = CLK_HZ,
  parameter int unsigned RD_LAT   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  output logic              tick
);

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
  } token_t;

  localparam token_t RESET_TOKEN = '{valid: 1'b1, addr: '0};

  logic                    step;
  logic                    launch;
  logic [ADDR_W-1:0]       rd_addr_q, rd_addr_d;
  token_t [RD_LAT-1:0]     pipe_q, pipe_d;
  token_t                  exit_tok;
  logic [ADDR_W-1:0]       disp_addr_q, disp_addr_d;
  logic [DATA_W-1:0]       disp_data_q, disp_data_d;
  logic                    disp_valid_q, disp_valid_d;

  tick_gen #(
    .DIV (TICK_DIV)
  ) u_tick_gen (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .clear  (load),
    .step   (step),
    .tick   (tick)
  );

  // load bypasses enable and overrides a step landing on the same edge.
  always_comb begin
    rd_addr_d = rd_addr_q;
    if (load) begin
      rd_addr_d = load_addr;
    end else if (step) begin
      rd_addr_d = rd_addr_q + ADDR_W'(1);
    end
  end

  assign launch = load | step;

  // Each address update enters stage 0 with its address and ages one stage per edge,
  // so it leaves exactly when the RAM has answered for that address.
  always_comb begin
    pipe_d    = '0;
    pipe_d[0] = '{valid: launch, addr: rd_addr_d};
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  assign exit_tok = pipe_q[RD_LAT-1];

  always_comb begin
    disp_addr_d  = disp_addr_q;
    disp_data_d  = disp_data_q;
    disp_valid_d = disp_valid_q;
    if (exit_tok.valid) begin
      disp_addr_d  = exit_tok.addr;
      disp_data_d  = rd_data;
      disp_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_addr_q    <= '0;
      // NOTE: the token pipeline is reset too, and preloaded with address 0 so the first word shows without a step.
      pipe_q       <= '0;
      pipe_q[0]    <= RESET_TOKEN;
      disp_addr_q  <= '0;
      disp_data_q  <= '0;
      disp_valid_q <= 1'b0;
    end else begin
      rd_addr_q    <= rd_addr_d;
      pipe_q       <= pipe_d;
      disp_addr_q  <= disp_addr_d;
      disp_data_q  <= disp_data_d;
      disp_valid_q <= disp_valid_d;
    end
  end

  assign rd_addr    = rd_addr_q;
  assign disp_addr  = disp_addr_q;
  assign disp_data  = disp_data_q;
  assign disp_valid = disp_valid_q;

endmodule

// File: tb/tb_ram_scan_reader.sv
// Bench for ram_scan_reader: two instances (TICK_DIV=4/RD_LAT=1 and TICK_DIV=1/RD_LAT=2)
// exercised one at a time against a cycle model and a scoreboard of expected display pairs.
module tb_ram_scan_reader;

  typedef struct {
    logic [4:0] addr;
    logic [3:0] data;
    int         due;
  } exp_t;

  function automatic int div_of(input int idx);
    return (idx == 0) ? 4 : 1;
  endfunction

  function automatic int lat_of(input int idx);
    return (idx == 0) ? 1 : 2;
  endfunction

  // RAM contents: instance 0 holds data[i]=i[3:0]; instance 1 a scrambled pattern.
  function automatic logic [3:0] ram_word(input int idx, input logic [4:0] a);
    logic [3:0] lo;
    lo = a[3:0];
    return (idx == 0) ? lo : (lo * 4'd5 + 4'd9);
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_s      [2];
  logic       enable_s     [2];
  logic       load_s       [2];
  logic [4:0] load_addr_s  [2];
  logic [4:0] rd_addr_s    [2];
  logic [3:0] rd_data_s    [2];
  logic [4:0] disp_addr_s  [2];
  logic [3:0] disp_data_s  [2];
  logic       disp_valid_s [2];
  logic       tick_s       [2];
  logic [4:0] ram_b_addr;

  // Instance 0 sees a RAM answering within the cycle; instance 1 one with a registered address.
  assign rd_data_s[0] = ram_word(0, rd_addr_s[0]);
  always @(posedge clk) ram_b_addr <= rd_addr_s[1];
  assign rd_data_s[1] = ram_word(1, ram_b_addr);

  ram_scan_reader #(.ADDR_W(5), .DATA_W(4), .TICK_DIV(4), .RD_LAT(1)) u_dut_a (
    .clk        (clk),
    .reset      (reset_s[0]),
    .enable     (enable_s[0]),
    .load       (load_s[0]),
    .load_addr  (load_addr_s[0]),
    .rd_addr    (rd_addr_s[0]),
    .rd_data    (rd_data_s[0]),
    .disp_addr  (disp_addr_s[0]),
    .disp_data  (disp_data_s[0]),
    .disp_valid (disp_valid_s[0]),
    .tick       (tick_s[0])
  );

  ram_scan_reader #(.ADDR_W(5), .DATA_W(4), .TICK_DIV(1), .RD_LAT(2)) u_dut_b (
    .clk        (clk),
    .reset      (reset_s[1]),
    .enable     (enable_s[1]),
    .load       (load_s[1]),
    .load_addr  (load_addr_s[1]),
    .rd_addr    (rd_addr_s[1]),
    .rd_data    (rd_data_s[1]),
    .disp_addr  (disp_addr_s[1]),
    .disp_data  (disp_data_s[1]),
    .disp_valid (disp_valid_s[1]),
    .tick       (tick_s[1])
  );

  int         n_checks = 0;
  int         n_errors = 0;
  int         edge_n   = 0;
  int         m_cnt    = 0;
  logic [4:0] m_addr   = '0;
  exp_t       exp_q[$];
  exp_t       cur;
  logic       cur_valid;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @edge %0d: got %0h expected %0h", tag, edge_n, got, exp);
    end
  endtask

  // Asserts reset between clock edges and checks outputs clear before any edge.
  task automatic do_reset(input int idx);
    reset_s[idx]     = 1'b1;
    enable_s[idx]    = 1'b0;
    load_s[idx]      = 1'b0;
    load_addr_s[idx] = '0;
    #1;
    check("rst_rd_addr",    rd_addr_s[idx],    0);
    check("rst_tick",       tick_s[idx],       0);
    check("rst_disp_valid", disp_valid_s[idx], 0);
    check("rst_disp_addr",  disp_addr_s[idx],  0);
    check("rst_disp_data",  disp_data_s[idx],  0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_s[idx] = 1'b0;
    edge_n    = 0;
    m_cnt     = 0;
    m_addr    = '0;
    cur       = '{addr: '0, data: '0, due: 0};
    cur_valid = 1'b0;
    exp_q.delete();
    exp_q.push_back('{addr: 5'd0, data: ram_word(idx, 5'd0), due: lat_of(idx)});
  endtask

  // One clock: drive inputs, advance the model, push any issued address, then check.
  task automatic cycle(input int idx, input logic en, input logic ld, input logic [4:0] la);
    logic step;
    enable_s[idx]    = en;
    load_s[idx]      = ld;
    load_addr_s[idx] = la;
    step = en && !ld && (m_cnt == div_of(idx) - 1);
    @(posedge clk);
    edge_n++;
    if (ld) begin
      m_addr = la;
      m_cnt  = 0;
    end else if (step) begin
      m_addr = m_addr + 5'd1;
      m_cnt  = 0;
    end else if (en) begin
      m_cnt++;
    end
    if (ld || step)
      exp_q.push_back('{addr: m_addr, data: ram_word(idx, m_addr), due: edge_n + lat_of(idx)});
    #1;
    check("rd_addr", rd_addr_s[idx], m_addr);
    check("tick",    tick_s[idx],    step);
    while (exp_q.size() != 0 && exp_q[0].due == edge_n) begin
      cur       = exp_q.pop_front();
      cur_valid = 1'b1;
    end
    check("disp_valid", disp_valid_s[idx], cur_valid);
    check("disp_addr",  disp_addr_s[idx],  cur.addr);
    check("disp_data",  disp_data_s[idx],  cur.data);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      reset_s[i]     = 1'b1;
      enable_s[i]    = 1'b0;
      load_s[i]      = 1'b0;
      load_addr_s[i] = '0;
    end
    @(posedge clk);
    #1;

    // Instance 0: TICK_DIV=4, RD_LAT=1.
    do_reset(0);
    repeat (4 * 34 + 2) cycle(0, 1'b1, 1'b0, 5'h00);       // first pairs, full wrap 31->0
    for (int k = 0; k < 8 && m_cnt != 2; k++) cycle(0, 1'b1, 1'b0, 5'h00);
    repeat (10) cycle(0, 1'b0, 1'b0, 5'h00);               // frozen mid-count
    repeat (6) cycle(0, 1'b1, 1'b0, 5'h00);
    for (int k = 0; k < 8 && m_cnt != 3; k++) cycle(0, 1'b1, 1'b0, 5'h00);
    cycle(0, 1'b1, 1'b1, 5'h1C);                           // load beats pending step
    repeat (5) cycle(0, 1'b1, 1'b0, 5'h00);
    cycle(0, 1'b1, 1'b1, 5'h05);                           // back-to-back loads
    cycle(0, 1'b0, 1'b1, 5'h1F);
    cycle(0, 1'b1, 1'b1, 5'h0A);
    repeat (6) cycle(0, 1'b1, 1'b0, 5'h00);
    cycle(0, 1'b1, 1'b1, 5'h13);                           // token in flight, then reset
    do_reset(0);
    repeat (8) cycle(0, 1'b1, 1'b0, 5'h00);
    reset_s[0] = 1'b1;

    // Instance 1: TICK_DIV=1, RD_LAT=2.
    do_reset(1);
    repeat (40) cycle(1, 1'b1, 1'b0, 5'h00);               // step every cycle, wraps
    cycle(1, 1'b1, 1'b1, 5'h1C);
    repeat (3) cycle(1, 1'b1, 1'b0, 5'h00);
    cycle(1, 1'b1, 1'b1, 5'h03);
    cycle(1, 1'b1, 1'b1, 5'h1E);
    cycle(1, 1'b0, 1'b1, 5'h11);
    repeat (4) cycle(1, 1'b0, 1'b0, 5'h00);                // in-flight tokens still land
    repeat (4) cycle(1, 1'b1, 1'b0, 5'h00);
    cycle(1, 1'b1, 1'b1, 5'h09);                           // two tokens in flight, then reset
    do_reset(1);
    repeat (6) cycle(1, 1'b1, 1'b0, 5'h00);
    reset_s[1] = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
